bram_stream_loader: RTL and testbench

- Upstream feeder for the team's simple-dual-port block RAM: 1 write port, 1 read port, 1-cycle read latency, read-first, no write bypass.
- Takes a valid/ready word stream framed as packets: base address, word count, then payload.
- Drives the RAM write port with registered wen/waddr/din, and reports completion and a payload checksum.
- Used to load instruction and data memories before execution; yields the write port to the core when `mem_busy` is asserted.

---
 rtl/bram_stream_loader.sv | 154 +++++++++++++++
 tb/tb_bram_stream_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
// bram_stream_loader
//
// Feeds the write port of a simple-dual-port block RAM from a valid/ready word
// stream. Each packet on the stream is a base address beat, a word count beat,
// and then that many payload words, which are written to consecutive RAM
// addresses. The address wraps at the top of the RAM. A running checksum of
// the payload is kept, and done pulses once per packet. The loader stops taking
// payload while another agent owns the write port (mem_busy).
//
// Parameters:
//   DATA_WIDTH     width of stream words and RAM data
//   ADDRESS_WIDTH  RAM address width
//
// Ports:
//   clock     rising-edge clock for all state
//   reset_n   asynchronous active-low reset
//   in_valid  upstream word valid
//   in_ready  loader accepts a word this cycle (from state and mem_busy only)
//   in_data   upstream word
//   mem_busy  write port is owned by someone else; payload is held off
//   wen       registered RAM write enable
//   waddr     registered RAM write address
//   din       registered RAM write data
//   active    a packet is in progress (header count or payload phase)
//   done      one-cycle pulse when a packet completes
//   checksum  sum of the payload words of the current/last packet, modulo 2^DATA_WIDTH

module bram_stream_loader #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     mem_busy,
    output logic                     wen,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     active,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    checksum
);

    typedef enum logic [1:0] {
        StBase = 2'd0,
        StLen  = 2'd1,
        StData = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [DATA_WIDTH-1:0]    remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]    checksum_q, checksum_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic                     done_q, done_d;
    logic                     beat;

    // Ready depends only on state and mem_busy so that upstream may wait on
    // ready before raising valid without creating a combinational loop.
    always_comb begin
        in_ready = 1'b1;
        if (state_q == StData) begin
            in_ready = ~mem_busy;
        end
    end

    assign beat = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        checksum_d  = checksum_q;
        waddr_d     = waddr_q;
        din_d       = din_q;
        wen_d       = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StBase: begin
                if (beat) begin
                    // Upper bits of the base word are ignored.
                    addr_ptr_d = in_data[ADDRESS_WIDTH-1:0];
                    checksum_d = '0;
                    state_d    = StLen;
                end
            end
            StLen: begin
                if (beat) begin
                    remaining_d = in_data;
                    if (in_data == '0) begin
                        // Empty packet: complete without touching the RAM.
                        done_d  = 1'b1;
                        state_d = StBase;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (beat) begin
                    wen_d       = 1'b1;
                    waddr_d     = addr_ptr_q;
                    din_d       = in_data;
                    addr_ptr_d  = addr_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    checksum_d  = checksum_q + in_data;
                    if (remaining_q == DATA_WIDTH'(1)) begin
                        // done lines up with the final write.
                        done_d  = 1'b1;
                        state_d = StBase;
                    end
                end
            end
            default: begin
                state_d = StBase;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StBase;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            checksum_q  <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            din_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            checksum_q  <= checksum_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            din_q       <= din_d;
            done_q      <= done_d;
        end
    end

    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign din      = din_q;
    assign done     = done_q;
    assign checksum = checksum_q;
    assign active   = (state_q != StBase);

endmodule

// File: tb/tb_bram_stream_loader.sv
module tb_bram_stream_loader;

    localparam int DW = 16;
    localparam int AW = 11;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          mem_busy = 1'b0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          active;
    logic          done;
    logic [DW-1:0] checksum;

    bram_stream_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mem_busy (mem_busy),
        .wen      (wen),
        .waddr    (waddr),
        .din      (din),
        .active   (active),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t           sb[$];
    int            wen_cycles[$];
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            wen_cnt = 0;
    int            done_cnt = 0;

    always @(posedge clock) cyc++;

    // Write-port monitor: every wen must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n) begin
            if (wen) begin
                wr_t e;
                wen_cnt++;
                wen_cycles.push_back(cyc);
                ram[waddr] = din;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wen: got waddr=%h din=%h done=%b, expected no write",
                             waddr, din, done);
                end else begin
                    e = sb.pop_front();
                    if ({waddr, din, done} !== {e.addr, e.data, e.last}) begin
                        bad++;
                        $display("FAIL write: got waddr=%h din=%h done=%b, expected %h %h %b",
                                 waddr, din, done, e.addr, e.data, e.last);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    // Must be entered just after a rising edge; returns just after the beat edge.
    task automatic send_word(input logic [DW-1:0] w, input bit is_payload,
                             input logic [AW-1:0] a, input bit last, input int gap_pct);
        int n;
        while (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready=0 after %0d cycles, expected 1", n);
        end
        if (is_payload) sb.push_back('{addr: a, data: w, last: last});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++;
        if ({wen, waddr, din, done, checksum, active, in_ready} !== {1'b0, 11'h0, 16'h0, 1'b0,
                                                                     16'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got wen=%b waddr=%h din=%h done=%b cs=%h act=%b rdy=%b",
                     wen, waddr, din, done, checksum, active, in_ready);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [3];
        int d0;
        w[0] = 16'hAAAA; w[1] = 16'h0001; w[2] = 16'h1234;
        d0 = done_cnt;
        wen_cycles.delete();
        send_word(16'h0010, 0, '0, 0, 0);
        send_word(16'd3, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) send_word(w[i], 1, AW'(16 + i), i == 2, 0);
        repeat (3) @(negedge clock);
        total++;
        if (checksum !== 16'hBCDF) begin
            bad++;
            $display("FAIL basic_checksum: got %h, expected BCDF", checksum);
        end
        total++;
        if (wen_cycles.size() != 3 || wen_cycles[2] - wen_cycles[0] != 2) begin
            bad++;
            $display("FAIL basic_consecutive: got %0d wens, expected 3 on consecutive cycles",
                     wen_cycles.size());
        end
        total++;
        if (done_cnt - d0 != 1 || active !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: got %0d done pulses active=%b, expected 1 and 0",
                     done_cnt - d0, active);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        int w0;
        w0 = wen_cnt;
        a = 11'h7FE;
        send_word(16'h07FE, 0, '0, 0, 0);
        send_word(16'd4, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send_word(16'hC000 + 16'(i), 1, a, i == 3, 0);
            a = a + 1'b1;
        end
        repeat (2) @(negedge clock);
        total++;
        if (wen_cnt - w0 != 4 || ram[0] !== 16'hC002 || ram[1] !== 16'hC003) begin
            bad++;
            $display("FAIL wrap: got %0d wens ram[0]=%h ram[1]=%h, expected 4 C002 C003",
                     wen_cnt - w0, ram[0], ram[1]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = wen_cnt;
        send_word(16'h0100, 0, '0, 0, 0);
        send_word(16'd0, 0, '0, 0, 0);
        @(negedge clock);
        total++;
        if (done !== 1'b1 || active !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: got done=%b active=%b, expected 1 0", done, active);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || wen_cnt != w0) begin
            bad++;
            $display("FAIL zero_nowrite: got done=%b wens=%0d, expected 0 0", done, wen_cnt - w0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_mem_busy();
        int w0;
        w0 = wen_cnt;
        send_word(16'h0100, 0, '0, 0, 0);
        send_word(16'd5, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send_word(16'h5000 + 16'(i), 1, AW'(16'h100 + i), i == 4, 0);
            if (i == 1) begin
                mem_busy = 1'b1;
                in_valid = 1'b1;
                in_data  = 16'h5002;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    total++;
                    if (in_ready !== 1'b0 || (k > 0 && wen !== 1'b0)) begin
                        bad++;
                        $display("FAIL busy_hold%0d: got in_ready=%b wen=%b, expected 0 0",
                                 k, in_ready, wen);
                    end
                    @(posedge clock);
                    #1;
                end
                mem_busy = 1'b0;
                @(negedge clock);
                total++;
                if (wen !== 1'b0 || in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_release: got wen=%b in_ready=%b, expected 0 1",
                             wen, in_ready);
                end
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        repeat (2) @(negedge clock);
        total++;
        if (wen_cnt - w0 != 5 || ram[12'h104] !== 16'h5004) begin
            bad++;
            $display("FAIL busy_count: got %0d wens ram[104]=%h, expected 5 5004",
                     wen_cnt - w0, ram[12'h104]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random_gaps();
        int            errs, w0;
        logic [AW-1:0] a;
        logic [DW-1:0] w, sum;
        int            addrs[$];
        w0 = wen_cnt;
        for (int p = 0; p < 2; p++) begin
            a   = AW'($urandom_range(0, (1 << AW) - 1));
            sum = '0;
            send_word(16'(a) | 16'hF800, 0, '0, 0, 50);
            send_word(16'd64, 0, '0, 0, 50);
            for (int i = 0; i < 64; i++) begin
                w = 16'($urandom);
                exp_mem[a] = w;
                addrs.push_back(int'(a));
                sum = sum + w;
                send_word(w, 1, a, i == 63, 50);
                a = a + 1'b1;
            end
            repeat (2) @(negedge clock);
            total++;
            if (checksum !== sum) begin
                bad++;
                $display("FAIL rand_checksum%0d: got %h, expected %h", p, checksum, sum);
            end
            @(posedge clock);
            #1;
        end
        errs = 0;
        foreach (addrs[i]) if (ram[addrs[i]] !== exp_mem[addrs[i]]) errs++;
        total++;
        if (errs != 0 || wen_cnt - w0 != 128) begin
            bad++;
            $display("FAIL rand_ram: got %0d bad words and %0d wens, expected 0 and 128",
                     errs, wen_cnt - w0);
        end
    endtask

    task automatic test_mid_reset();
        int d0, w0;
        send_word(16'h0180, 0, '0, 0, 0);
        send_word(16'd6, 0, '0, 0, 0);
        send_word(16'h7A01, 1, 11'h180, 0, 0);
        send_word(16'h7A02, 1, 11'h181, 0, 0);
        reset_n = 1'b0;
        #1;
        total++;
        if ({wen, waddr, din, done, checksum, active} !== '0) begin
            bad++;
            $display("FAIL async_reset: got wen=%b waddr=%h din=%h done=%b cs=%h act=%b, expected 0",
                     wen, waddr, din, done, checksum, active);
        end
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        d0 = done_cnt;
        w0 = wen_cnt;
        send_word(16'h0200, 0, '0, 0, 0);
        send_word(16'd1, 0, '0, 0, 0);
        send_word(16'hBEEF, 1, 11'h200, 1, 0);
        send_word(16'h0300, 0, '0, 0, 0);
        @(negedge clock);
        total++;
        if (ram[12'h200] !== 16'hBEEF || ram[12'h180] !== 16'h7A01 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL after_reset: got ram200=%h ram180=%h dones=%0d, expected BEEF 7A01 1",
                     ram[12'h200], ram[12'h180], done_cnt - d0);
        end
        total++;
        if (active !== 1'b1 || wen_cnt - w0 != 1) begin
            bad++;
            $display("FAIL next_is_base: got active=%b wens=%0d, expected 1 1",
                     active, wen_cnt - w0);
        end
        @(posedge clock);
        #1;
        send_word(16'd0, 0, '0, 0, 0);
        repeat (2) @(negedge clock);
        total++;
        if (sb.size() != 0 || active !== 1'b0) begin
            bad++;
            $display("FAIL drain: got %0d pending writes active=%b, expected 0 0",
                     sb.size(), active);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = '0;
            exp_mem[i] = '0;
        end
        #2;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_mem_busy();
        test_random_gaps();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
